// File: rtl/pool_window_gen.sv
// pool_window_gen: streams raster pixels and emits non-overlapping 2x2 windows for the max-pool.
module pool_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     win_valid,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic                     frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [DATA_W-1:0] line_q [IMG_W];
  logic signed [DATA_W-1:0] line_d [IMG_W];
  logic signed [DATA_W-1:0] bl_q, bl_d;
  logic signed [DATA_W-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d, w4_q, w4_d;
  logic wv_q, wv_d, fd_q, fd_d;
  logic last_col, last_row, fire;
  always_comb begin
    last_col = col_q == COL_MAX;
    last_row = row_q == ROW_MAX;
    fire     = in_valid && row_q[0] && col_q[0];
    col_d    = in_valid ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d    = (in_valid && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    line_d   = line_q;
    if (in_valid && !row_q[0]) line_d[col_q] = in_data;
    bl_d     = (in_valid && row_q[0] && !col_q[0]) ? in_data : bl_q;
    // odd rows never write the line buffer, so both reads see the previous even row
    w1_d     = fire ? line_q[col_q - CW'(1)] : w1_q;
    w2_d     = fire ? line_q[col_q] : w2_q;
    w3_d     = fire ? bl_q : w3_q;
    w4_d     = fire ? in_data : w4_q;
    wv_d     = fire;
    fd_d     = fire && last_col && last_row;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      bl_q  <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      w3_q  <= '0;
      w4_q  <= '0;
      wv_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      bl_q  <= bl_d;
      w1_q  <= w1_d;
      w2_q  <= w2_d;
      w3_q  <= w3_d;
      w4_q  <= w4_d;
      wv_q  <= wv_d;
      fd_q  <= fd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) line_q <= line_d;
  end
  assign win_valid  = wv_q;
  assign frame_done = fd_q;
  assign win1 = w1_q;
  assign win2 = w2_q;
  assign win3 = w3_q;
  assign win4 = w4_q;
endmodule
